// File: rtl/flag_unit.sv
// Condition-code register (Z/N/C) with jump resolution, SETC/CLRC and a
// LIFO shadow stack that saves the CCR on interrupt entry and restores it on RTI.
module flag_unit #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_stall,
    input  logic                           i_flag_we,
    input  logic                           i_alu_zero,
    input  logic                           i_alu_negative,
    input  logic                           i_alu_carry,
    input  logic                           i_setc,
    input  logic                           i_clrc,
    input  logic [1:0]                     i_jmp_cond,
    input  logic                           i_save,
    input  logic                           i_restore,
    output logic                           o_zero_flag,
    output logic                           o_negative_flag,
    output logic                           o_carry_flag,
    output logic                           o_branch_taken,
    output logic [$clog2(DEPTH+1)-1:0]     o_depth,
    output logic                           o_overflow,
    output logic                           o_underflow
);

    localparam int unsigned DW = $clog2(DEPTH + 1);

    logic          z_q, z_d, n_q, n_d, c_q, c_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic [DW-1:0] sp_q, sp_d;
    logic [2:0]    stack_q [DEPTH];
    logic [2:0]    stack_d [DEPTH];
    logic [2:0]    top;
    logic          take_z, take_n, take_c;
    logic          fz, fn, fc;

    always_comb begin
        unique case (i_jmp_cond)
            2'b01:   o_branch_taken = z_q;
            2'b10:   o_branch_taken = n_q;
            2'b11:   o_branch_taken = c_q;
            default: o_branch_taken = 1'b0;
        endcase
    end

    assign take_z = (i_jmp_cond == 2'b01) && z_q;
    assign take_n = (i_jmp_cond == 2'b10) && n_q;
    assign take_c = (i_jmp_cond == 2'b11) && c_q;

    // Per-bit flag update as it would apply if no restore pops the stack.
    always_comb begin
        fz = take_z ? 1'b0 : (i_flag_we ? i_alu_zero : z_q);
        fn = take_n ? 1'b0 : (i_flag_we ? i_alu_negative : n_q);
        if (take_c)         fc = 1'b0;
        else if (i_setc)    fc = 1'b1;
        else if (i_clrc)    fc = 1'b0;
        else if (i_flag_we) fc = i_alu_carry;
        else                fc = c_q;
    end

    always_comb begin
        top = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (DW'(i + 1) == sp_q) top = stack_q[i];
        end
    end

    always_comb begin
        z_d     = z_q;
        n_d     = n_q;
        c_d     = c_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        stack_d = stack_q;
        if (!i_stall) begin
            if (i_restore) begin
                if (sp_q != '0) begin
                    {z_d, n_d, c_d} = top;
                    sp_d            = sp_q - DW'(1);
                end else begin
                    unf_d           = 1'b1;
                    {z_d, n_d, c_d} = {fz, fn, fc};
                end
            end else begin
                if (i_save) begin
                    if (sp_q != DW'(DEPTH)) begin
                        for (int unsigned i = 0; i < DEPTH; i++) begin
                            if (DW'(i) == sp_q) stack_d[i] = {z_q, n_q, c_q};
                        end
                        sp_d = sp_q + DW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                {z_d, n_d, c_d} = {fz, fn, fc};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            c_q   <= 1'b0;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) stack_q[i] <= '0;
        end else begin
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            stack_q <= stack_d;
        end
    end

    assign o_zero_flag     = z_q;
    assign o_negative_flag = n_q;
    assign o_carry_flag    = c_q;
    assign o_depth         = sp_q;
    assign o_overflow      = ovf_q;
    assign o_underflow     = unf_q;

endmodule

// File: tb/tb_flag_unit.sv
// Directed table-driven bench for flag_unit (DEPTH=4): each row is applied for
// one cycle; branch_taken is checked before the edge, CCR/stack state after it.
module tb_flag_unit;

    logic       clk = 1'b0;
    logic       reset, stall, flag_we, alu_z, alu_n, alu_c, setc, clrc, save, restore;
    logic [1:0] jmp;
    logic       o_z, o_n, o_c, o_br, o_ovf, o_unf;
    logic [2:0] o_dep;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    flag_unit #(.DEPTH(4)) dut (
        .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_flag_we(flag_we),
        .i_alu_zero(alu_z), .i_alu_negative(alu_n), .i_alu_carry(alu_c),
        .i_setc(setc), .i_clrc(clrc), .i_jmp_cond(jmp), .i_save(save),
        .i_restore(restore), .o_zero_flag(o_z), .o_negative_flag(o_n),
        .o_carry_flag(o_c), .o_branch_taken(o_br), .o_depth(o_dep),
        .o_overflow(o_ovf), .o_underflow(o_unf)
    );

    typedef struct {
        logic       rst, stl, we;
        logic [2:0] alu;     // Z,N,C
        logic       st, cl;
        logic [1:0] jc;
        logic       sv, rs;
        logic       br;
        logic [2:0] ccr;     // expected Z,N,C after the edge
        logic [2:0] dep;
        logic       ovf, unf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic rst, logic stl, logic we, logic [2:0] alu,
                               logic st, logic cl, logic [1:0] jc, logic sv,
                               logic rs, logic br, logic [2:0] ccr,
                               logic [2:0] dep, logic ovf, logic unf);
        vec_t r;
        r.rst = rst; r.stl = stl; r.we = we; r.alu = alu; r.st = st; r.cl = cl;
        r.jc = jc; r.sv = sv; r.rs = rs; r.br = br; r.ccr = ccr; r.dep = dep;
        r.ovf = ovf; r.unf = unf;
        return r;
    endfunction

    task automatic check_state(string name, logic [2:0] ccr, logic [2:0] dep,
                               logic ovf, logic unf);
        logic [7:0] act, exp;
        act = {o_z, o_n, o_c, o_dep, o_ovf, o_unf};
        exp = {ccr, dep, ovf, unf};
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got znc=%b dep=%0d ovf=%b unf=%b, expected znc=%b dep=%0d ovf=%b unf=%b",
                      name, act[7:5], act[4:2], act[1], act[0], ccr, dep, ovf, unf);
    endtask

    task automatic drive(vec_t r);
        reset = r.rst; stall = r.stl; flag_we = r.we;
        {alu_z, alu_n, alu_c} = r.alu;
        setc = r.st; clrc = r.cl; jmp = r.jc; save = r.sv; restore = r.rs;
    endtask

    initial begin
        drive(v(1, 0, 0, 3'b000, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0));
        //        rst stl we alu   st cl jc     sv rs br ccr     dep ovf unf
        vecs.push_back(v(1, 0, 0, 3'b000, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0)); // 0 reset
        vecs.push_back(v(0, 0, 1, 3'b101, 0, 0, 2'b00, 0, 0, 0, 3'b101, 0, 0, 0)); // 1 flag_we
        vecs.push_back(v(0, 0, 0, 3'b000, 0, 0, 2'b11, 0, 0, 1, 3'b100, 0, 0, 0)); // 2 JC taken
        vecs.push_back(v(0, 0, 1, 3'b101, 0, 0, 2'b01, 0, 0, 1, 3'b001, 0, 0, 0)); // 3 JZ beats we
        vecs.push_back(v(0, 0, 1, 3'b011, 0, 0, 2'b11, 0, 0, 1, 3'b010, 0, 0, 0)); // 4 JC beats we C=1
        vecs.push_back(v(0, 0, 0, 3'b000, 0, 0, 2'b10, 0, 0, 1, 3'b000, 0, 0, 0)); // 5 JN taken
        vecs.push_back(v(0, 0, 0, 3'b000, 1, 0, 2'b01, 0, 0, 0, 3'b001, 0, 0, 0)); // 6 JZ not taken, setc
        vecs.push_back(v(0, 0, 0, 3'b000, 1, 1, 2'b00, 0, 0, 0, 3'b001, 0, 0, 0)); // 7 setc beats clrc
        vecs.push_back(v(0, 0, 1, 3'b101, 0, 1, 2'b00, 0, 0, 0, 3'b100, 0, 0, 0)); // 8 clrc beats we
        vecs.push_back(v(0, 0, 1, 3'b101, 0, 0, 2'b00, 0, 0, 0, 3'b101, 0, 0, 0)); // 9
        vecs.push_back(v(0, 0, 1, 3'b010, 0, 0, 2'b00, 1, 0, 0, 3'b010, 1, 0, 0)); // 10 save + we
        vecs.push_back(v(0, 0, 0, 3'b000, 0, 0, 2'b00, 0, 1, 0, 3'b101, 0, 0, 0)); // 11 restore
        vecs.push_back(v(0, 0, 1, 3'b011, 0, 0, 2'b00, 0, 1, 0, 3'b011, 0, 0, 1)); // 12 underflow, we applies
        vecs.push_back(v(1, 0, 0, 3'b000, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0)); // 13 reset clears sticky
        vecs.push_back(v(0, 0, 1, 3'b101, 0, 0, 2'b00, 0, 0, 0, 3'b101, 0, 0, 0)); // 14
        vecs.push_back(v(0, 0, 1, 3'b110, 0, 0, 2'b00, 1, 0, 0, 3'b110, 1, 0, 0)); // 15 push 101
        vecs.push_back(v(0, 0, 1, 3'b011, 0, 0, 2'b00, 1, 0, 0, 3'b011, 2, 0, 0)); // 16 push 110
        vecs.push_back(v(0, 0, 1, 3'b000, 0, 0, 2'b00, 1, 0, 0, 3'b000, 3, 0, 0)); // 17 push 011
        vecs.push_back(v(0, 0, 0, 3'b000, 1, 0, 2'b00, 1, 0, 0, 3'b001, 4, 0, 0)); // 18 push 000
        vecs.push_back(v(0, 0, 1, 3'b111, 0, 0, 2'b00, 1, 0, 0, 3'b111, 4, 1, 0)); // 19 overflow, we applies
        vecs.push_back(v(0, 1, 1, 3'b000, 1, 0, 2'b11, 1, 0, 1, 3'b111, 4, 1, 0)); // 20 stall holds, br valid
        vecs.push_back(v(0, 0, 1, 3'b111, 0, 0, 2'b00, 1, 1, 0, 3'b000, 3, 1, 0)); // 21 pop, save/we ignored
        vecs.push_back(v(0, 0, 0, 3'b000, 0, 0, 2'b00, 0, 1, 0, 3'b011, 2, 1, 0)); // 22
        vecs.push_back(v(0, 0, 0, 3'b000, 0, 0, 2'b00, 0, 1, 0, 3'b110, 1, 1, 0)); // 23
        vecs.push_back(v(0, 0, 0, 3'b000, 0, 0, 2'b00, 0, 1, 0, 3'b101, 0, 1, 0)); // 24 first saved
        vecs.push_back(v(0, 0, 0, 3'b000, 0, 0, 2'b00, 0, 1, 0, 3'b101, 0, 1, 1)); // 25 underflow
        vecs.push_back(v(0, 1, 0, 3'b000, 0, 0, 2'b00, 0, 1, 0, 3'b101, 0, 1, 1)); // 26 stall restore
        vecs.push_back(v(0, 0, 0, 3'b000, 0, 0, 2'b00, 1, 0, 0, 3'b101, 1, 1, 1)); // 27
        vecs.push_back(v(0, 0, 0, 3'b000, 0, 0, 2'b00, 1, 0, 0, 3'b101, 2, 1, 1)); // 28
        vecs.push_back(v(0, 0, 0, 3'b000, 0, 0, 2'b00, 1, 0, 0, 3'b101, 3, 1, 1)); // 29
        vecs.push_back(v(1, 0, 1, 3'b111, 1, 0, 2'b00, 1, 1, 0, 3'b000, 0, 0, 0)); // 30 reset mid-save/restore
        vecs.push_back(v(0, 0, 0, 3'b000, 0, 0, 2'b00, 0, 1, 0, 3'b000, 0, 0, 1)); // 31 stack emptied

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            total++;
            if (o_br === vecs[i].br) passed++;
            else $display("FAIL branch_taken row %0d: got %b, expected %b", i, o_br, vecs[i].br);
            @(posedge clk); #1;
            check_state($sformatf("state row %0d", i), vecs[i].ccr, vecs[i].dep,
                        vecs[i].ovf, vecs[i].unf);
        end

        // Overflow stays sticky across idle cycles until reset.
        drive(v(0, 0, 0, 3'b000, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            save = 1'b1;
            @(posedge clk); #1;
        end
        save = 1'b0;
        check_state("five saves", 3'b000, 3'd4, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_state($sformatf("sticky idle %0d", k), 3'b000, 3'd4, 1'b1, 1'b1);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_state("final reset", 3'b000, 3'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
